// File: rtl/serial_cmd_pkg.sv
// serial_cmd_pkg: shared definitions for the serial command sequencer.
// Holds the command opcodes, the fixed response words and the FSM state
// encoding used by serial_cmd_ctrl and serial_tx_seq.
package serial_cmd_pkg;

  localparam logic [7:0] CMD_ADDR     = 8'h01;
  localparam logic [7:0] CMD_LOAD     = 8'h02;
  localparam logic [7:0] CMD_WRITE    = 8'h03;
  localparam logic [7:0] CMD_READ     = 8'h04;
  localparam logic [7:0] CMD_READ_REQ = 8'h05;
  localparam logic [7:0] CMD_COUNT    = 8'h06;
  localparam logic [7:0] CMD_CONST    = 8'h07;

  localparam logic [31:0] RESP_CONST   = 32'h0101_0101;
  localparam logic [31:0] RESP_BAD     = 32'hFFFF_FFFF;
  localparam logic [31:0] RESP_TIMEOUT = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    RX       = 3'd0,
    EXEC     = 3'd1,
    MEM_WAIT = 3'd2,
    TX_LOAD  = 3'd3,
    TX_BUSY  = 3'd4,
    TX_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/serial_tx_seq.sv
// serial_tx_seq: sends a 32-bit response word as exactly four bytes, MSB
// first, through a uart_tx-style start/ready handshake.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   load, word       one-cycle pulse capturing the word to send
//   tx_ready         transmitter idle
//   tx_data          byte currently offered to the transmitter
//   tx_start         one-cycle start strobe, only ever raised with tx_ready=1
//   done             one-cycle pulse as the fourth byte is accepted
//
// state   | meaning
// RX      | idle, nothing to send
// TX_LOAD | waiting for tx_ready, then strobe the current byte
// TX_BUSY | waiting for tx_ready to drop (start latency of the transmitter)
// TX_DONE | waiting for tx_ready to return, then advance to the next byte
module serial_tx_seq
  import serial_cmd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] word,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        done
);

  state_t      st, st_nxt;
  logic [31:0] shift;
  logic [1:0]  idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= RX;
      shift <= 32'h0;
      idx   <= 2'd0;
    end else begin
      st <= st_nxt;
      if (load) begin
        shift <= word;
        idx   <= 2'd0;
      end else if (st == TX_DONE && tx_ready) begin
        shift <= {shift[23:0], 8'h00};
        idx   <= idx + 2'd1;
      end
    end
  end

  always_comb begin
    st_nxt   = st;
    tx_start = 1'b0;
    done     = 1'b0;
    case (st)
      RX:      if (load) st_nxt = TX_LOAD;
      TX_LOAD: if (tx_ready) begin
                 tx_start = 1'b1;
                 st_nxt   = TX_BUSY;
               end
      TX_BUSY: if (!tx_ready) st_nxt = TX_DONE;
      TX_DONE: if (tx_ready) begin
                 if (idx == 2'd3) begin
                   done   = 1'b1;
                   st_nxt = RX;
                 end else begin
                   st_nxt = TX_LOAD;
                 end
               end
      default: st_nxt = RX;
    endcase
  end

  assign tx_data = shift[31:24];

endmodule

// File: rtl/serial_cmd_ctrl.sv
// serial_cmd_ctrl: assembles 5-byte command frames from the UART receiver,
// executes them against the SRAM request interface or internal registers,
// and returns a 4-byte response through serial_tx_seq.
// Ports:
//   clk, rstn                       clock, async active-low reset
//   rx_data, rx_rcv                 received byte and its one-cycle strobe
//   tx_data, tx_start, tx_ready     transmitter handshake
//   mem_addr, mem_wdata             SRAM address / write data registers
//   mem_wr_req, mem_rd_req          one-cycle SRAM requests
//   mem_rdata, mem_done             SRAM read data and completion pulse
//   busy                            high whenever a frame is being handled
//   err_overrun                     sticky: a byte arrived outside RX
//
// state    | meaning
// RX       | collecting frame bytes
// EXEC     | one cycle: decode cmd, update registers, issue memory request
// MEM_WAIT | waiting for mem_done or the memory timeout
// TX_LOAD  | response handed to serial_tx_seq, waiting for its done pulse
module serial_cmd_ctrl
  import serial_cmd_pkg::*;
#(
  parameter int          RX_TIMEOUT  = 100000,
  parameter int          MEM_TIMEOUT = 1024,
  parameter logic [31:0] COUNT_INIT  = 32'h0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rx_data,
  input  logic        rx_rcv,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr_req,
  output logic        mem_rd_req,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done,
  output logic        busy,
  output logic        err_overrun
);

  localparam logic [31:0] RX_TMR_LOAD  = 32'(RX_TIMEOUT - 1);
  localparam logic [31:0] MEM_TMR_LOAD = 32'(MEM_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [39:0] frame;
  logic [2:0]  rx_idx;
  logic [31:0] rx_tmr;
  logic [31:0] mem_tmr;
  logic [31:0] rd_latch;
  logic [31:0] count;
  logic        tx_load;
  logic [31:0] resp_word;
  logic        tx_done;
  logic [7:0]  cmd;
  logic [31:0] d;

  assign cmd  = frame[39:32];
  assign d    = frame[31:0];
  assign busy = (state != RX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= RX;
      frame       <= 40'h0;
      rx_idx      <= 3'd0;
      rx_tmr      <= 32'h0;
      mem_tmr     <= 32'h0;
      rd_latch    <= 32'h0;
      count       <= COUNT_INIT;
      mem_addr    <= 32'h0;
      mem_wdata   <= 32'h0;
      err_overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      if (rx_rcv && state != RX) err_overrun <= 1'b1;

      if (state == RX) begin
        if (rx_rcv) begin
          frame  <= {frame[31:0], rx_data};
          rx_idx <= (rx_idx == 3'd4) ? 3'd0 : rx_idx + 3'd1;
          rx_tmr <= RX_TMR_LOAD;
        end else if (rx_idx != 3'd0) begin
          // Partial frame: silently discard once the line has been idle too long.
          if (rx_tmr == 32'h0) rx_idx <= 3'd0;
          else                 rx_tmr <= rx_tmr - 32'h1;
        end
      end

      if (state == EXEC) begin
        mem_tmr <= MEM_TMR_LOAD;
        case (cmd)
          CMD_ADDR:  mem_addr  <= d;
          CMD_LOAD:  mem_wdata <= d;
          CMD_COUNT: count     <= count + 32'h1;
          default:   ;
        endcase
      end

      if (state == MEM_WAIT) begin
        if (mem_done) begin
          if (cmd == CMD_READ_REQ) rd_latch <= mem_rdata;
        end else if (mem_tmr != 32'h0) begin
          mem_tmr <= mem_tmr - 32'h1;
        end
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    tx_load    = 1'b0;
    resp_word  = 32'h0;
    mem_wr_req = 1'b0;
    mem_rd_req = 1'b0;
    case (state)
      RX: if (rx_rcv && rx_idx == 3'd4) state_nxt = EXEC;
      EXEC: begin
        case (cmd)
          CMD_WRITE: begin
            mem_wr_req = 1'b1;
            state_nxt  = MEM_WAIT;
          end
          CMD_READ_REQ: begin
            mem_rd_req = 1'b1;
            state_nxt  = MEM_WAIT;
          end
          default: begin
            tx_load   = 1'b1;
            state_nxt = TX_LOAD;
            case (cmd)
              CMD_ADDR, CMD_LOAD: resp_word = d;
              CMD_READ:           resp_word = rd_latch;
              CMD_COUNT:          resp_word = count;
              CMD_CONST:          resp_word = RESP_CONST;
              default:            resp_word = RESP_BAD;
            endcase
          end
        endcase
      end
      MEM_WAIT: begin
        // A completion coinciding with terminal count wins over the timeout.
        if (mem_done) begin
          tx_load   = 1'b1;
          resp_word = {24'h0, cmd};
          state_nxt = TX_LOAD;
        end else if (mem_tmr == 32'h0) begin
          tx_load   = 1'b1;
          resp_word = RESP_TIMEOUT;
          state_nxt = TX_LOAD;
        end
      end
      TX_LOAD: if (tx_done) state_nxt = RX;
      default: state_nxt = RX;
    endcase
  end

  serial_tx_seq u_tx_seq (
    .clk      (clk),
    .rst_n    (rstn),
    .load     (tx_load),
    .word     (resp_word),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .done     (tx_done)
  );

endmodule

// File: tb/tb_serial_cmd_ctrl.sv
module tb_serial_cmd_ctrl;

  localparam int RXT = 40;
  localparam int MT  = 32;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  rx_data;
  logic        rx_rcv;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wr_req, mem_rd_req, mem_done;
  logic        busy, err_overrun;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_tx     = 0;
  int          n_wr     = 0;
  int          n_rd     = 0;
  int          mem_delay = 3;
  logic [31:0] mem_rdata_val = 32'h0;
  bit          sb_off = 1'b0;
  logic [7:0]  exp_q[$];
  logic [7:0]  mon_exp;

  always #5 clk = ~clk;

  serial_cmd_ctrl #(.RX_TIMEOUT(RXT), .MEM_TIMEOUT(MT), .COUNT_INIT(32'h0)) dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_rcv(rx_rcv),
    .tx_data(tx_data), .tx_start(tx_start), .tx_ready(tx_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_req(mem_wr_req),
    .mem_rd_req(mem_rd_req), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .busy(busy), .err_overrun(err_overrun)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_rcv  = 1'b1;
    @(posedge clk); #1;
    rx_rcv  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [31:0] w);
    send_byte(c);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    repeat (2) @(posedge clk);
    while ((busy || exp_q.size() != 0) && k < 3000) begin
      @(posedge clk);
      k++;
    end
    n_checks++;
    if (k >= 3000) begin
      n_fail++;
      $display("FAIL %s_idle: still busy after %0d cycles, required idle", name, k);
    end
    check32({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (4) @(posedge clk);
  endtask

  // Scoreboard monitor: every start strobe consumes one expected byte.
  always @(negedge clk) begin
    if (rstn && tx_start) begin
      n_tx++;
      n_checks++;
      if (!tx_ready) begin
        n_fail++;
        $display("FAIL tx_start_ready: tx_start with tx_ready=%b, required 1", tx_ready);
      end
      if (!sb_off) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL tx_extra: got byte %h, required no byte", tx_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (tx_data !== mon_exp) begin
            n_fail++;
            $display("FAIL tx_byte: got %h expected %h", tx_data, mon_exp);
          end
        end
      end
    end
  end

  // Transmitter: stays ready 2 cycles after a start, then busy 4 cycles.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rstn && tx_start) begin
        @(posedge clk);
        @(posedge clk); #1 tx_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 tx_ready = 1'b1;
      end
    end
  end

  // SRAM: answers a request after mem_delay cycles, or never when negative.
  initial begin
    mem_done  = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_wr_req) n_wr++;
      if (mem_rd_req) n_rd++;
      if ((mem_wr_req || mem_rd_req) && mem_delay > 0) begin
        repeat (mem_delay) @(posedge clk);
        #1 mem_done = 1'b1;
        mem_rdata = mem_rdata_val;
        @(posedge clk);
        #1 mem_done = 1'b0;
        mem_rdata = 32'h0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn    = 1'b0;
    rx_rcv  = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_tx_start", {31'h0, tx_start}, 32'h0);
    check32("rst_busy", {31'h0, busy}, 32'h0);
    check32("rst_overrun", {31'h0, err_overrun}, 32'h0);
    check32("rst_mem_addr", mem_addr, 32'h0);
    check32("rst_mem_wdata", mem_wdata, 32'h0);
    check32("rst_mem_req", {30'h0, mem_wr_req, mem_rd_req}, 32'h0);
    @(posedge clk); #1 rstn = 1'b1;

    // COUNT twice
    push_word(32'h0000_0000);
    send_frame(8'h06, 32'h0);
    wait_idle("count0");
    push_word(32'h0000_0001);
    send_frame(8'h06, 32'h0);
    wait_idle("count1");
    check32("tx_pulses_8", 32'(n_tx), 32'd8);

    // ADDR, LOAD, WRITE
    push_word(32'h0000_0104);
    send_frame(8'h01, 32'h0000_0104);
    wait_idle("addr");
    push_word(32'h1234_5678);
    send_frame(8'h02, 32'h1234_5678);
    wait_idle("load");
    mem_delay = 3;
    push_word(32'h0000_0003);
    send_frame(8'h03, 32'h0);
    wait_idle("write");
    check32("mem_addr", mem_addr, 32'h0000_0104);
    check32("mem_wdata", mem_wdata, 32'h1234_5678);
    check32("wr_pulses", 32'(n_wr), 32'd1);
    check32("rd_pulses0", 32'(n_rd), 32'd0);

    // READ_REQ then READ
    mem_rdata_val = 32'hCAFE_F00D;
    mem_delay = 10;
    push_word(32'h0000_0005);
    send_frame(8'h05, 32'h0);
    wait_idle("readreq");
    check32("rd_pulses1", 32'(n_rd), 32'd1);
    push_word(32'hCAFE_F00D);
    send_frame(8'h04, 32'h0);
    wait_idle("read");

    // READ_REQ timing out keeps the old latch
    mem_rdata_val = 32'h1111_2222;
    mem_delay = -1;
    push_word(32'hDEAD_BEEF);
    send_frame(8'h05, 32'h0);
    wait_idle("memto");
    push_word(32'hCAFE_F00D);
    send_frame(8'h04, 32'h0);
    wait_idle("read_after_to");
    check32("rd_pulses2", 32'(n_rd), 32'd2);

    // Partial frame discarded, then CONST with minimum turnaround
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    repeat (RXT + 1) @(posedge clk);
    check32("partial_busy", {31'h0, busy}, 32'h0);
    push_word(32'h0101_0101);
    send_frame(8'h07, 32'h0);
    @(negedge clk);
    check32("turn_exec", {31'h0, tx_start}, 32'h0);
    @(negedge clk);
    check32("turn_start", {31'h0, tx_start}, 32'h1);
    wait_idle("const");

    // Unknown command
    push_word(32'hFFFF_FFFF);
    send_frame(8'h5A, 32'h0);
    wait_idle("bad");

    // Overrun during transmission
    check32("pre_overrun", {31'h0, err_overrun}, 32'h0);
    push_word(32'h0101_0101);
    send_frame(8'h07, 32'h0);
    repeat (6) @(posedge clk);
    send_byte(8'h55);
    wait_idle("overrun");
    check32("overrun", {31'h0, err_overrun}, 32'h1);
    push_word(32'h0000_0002);
    send_frame(8'h06, 32'h0);
    wait_idle("count2");

    // Reset mid-transmit
    sb_off = 1'b1;
    send_frame(8'h06, 32'h0);
    repeat (8) @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    check32("midrst_tx_start", {31'h0, tx_start}, 32'h0);
    check32("midrst_busy", {31'h0, busy}, 32'h0);
    check32("midrst_overrun", {31'h0, err_overrun}, 32'h0);
    check32("midrst_mem_addr", mem_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (20) @(posedge clk);
    sb_off = 1'b0;
    push_word(32'h0000_0000);
    send_frame(8'h06, 32'h0);
    wait_idle("count_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_cmd_ctrl.md
Name: serial_cmd_ctrl

Overview:
Command sequencer between the UART receiver/transmitter pair and the SRAM driver.
- Assembles 5-byte frames (1 command byte followed by 32-bit data, MSB first) from rx strobes.
- Executes the command against the SRAM request interface or internal registers.
- Returns exactly 4 response bytes, MSB first, through a uart_tx-style start/ready handshake.
- Replaces ad-hoc byte counting with a single state machine. Never emits a spurious fifth byte.

Parameters:
RX_TIMEOUT, 100000, idle clk cycles after which a partial frame is discarded
MEM_TIMEOUT, 1024, clk cycles to wait for mem_done before aborting the SRAM operation
COUNT_INIT, 0, reset value of the internal 32-bit counter

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
rx_data  in  8  received byte, valid when rx_rcv=1
rx_rcv  in  1  one-cycle strobe, one byte received
tx_data  out  8  byte to transmit
tx_start  out  1  one-cycle transmit strobe
tx_ready  in  1  transmitter idle
mem_addr  out  32  SRAM address register
mem_wdata  out  32  SRAM write data register
mem_wr_req  out  1  one-cycle write request
mem_rd_req  out  1  one-cycle read request
mem_rdata  in  32  read data, valid with mem_done
mem_done  in  1  one-cycle completion pulse
busy  out  1  high in any state other than RX
err_overrun  out  1  sticky; set when a byte is dropped; cleared only by reset

Behaviour:
- Reset values: all outputs 0; mem_addr=0, mem_wdata=0; rd_latch=0; count=COUNT_INIT; state RX with byte index 0.
- RX state:
  - Each rx_rcv shifts rx_data into a 40-bit frame register and increments the index 0..4.
  - When the 5th byte arrives, go to EXEC on the next cycle.
  - The timeout counter clears on every rx_rcv. If the index is nonzero and RX_TIMEOUT cycles pass without rx_rcv, set index to 0. No response is sent.
- rx_rcv in any state other than RX: the byte is discarded and err_overrun is set.
- EXEC is one cycle. cmd is frame[39:32]; d is frame[31:0]. The response register resp is loaded as follows:
  - 0x01 ADDR: mem_addr<=d; resp=d.
  - 0x02 LOAD: mem_wdata<=d; resp=d.
  - 0x03 WRITE: pulse mem_wr_req; go to MEM_WAIT; resp=0x00000003 on completion.
  - 0x04 READ: resp=rd_latch.
  - 0x05 READ_REQ: pulse mem_rd_req; go to MEM_WAIT; on mem_done, rd_latch<=mem_rdata and resp=0x00000005.
  - 0x06 COUNT: resp=count; count<=count+1, wrapping 0xFFFFFFFF->0.
  - 0x07 CONST: resp=0x01010101.
  - Any other cmd: resp=0xFFFFFFFF.
  - Non-memory commands go to TX_LOAD.
- MEM_WAIT: wait for mem_done. If MEM_TIMEOUT cycles pass without it, resp=0xDEADBEEF and rd_latch is unchanged. mem_done arriving in the same cycle as the timeout counts as completion. Then go to TX_LOAD.
- Transmit sequence, with 2-bit tx index starting at 0:
  - TX_LOAD: wait for tx_ready=1. Drive tx_data=resp[31:24], pulse tx_start for one cycle, go to TX_BUSY.
  - TX_BUSY: wait for tx_ready=0, which absorbs the transmitter's 2-cycle start latency, then go to TX_DONE.
  - TX_DONE: wait for tx_ready=1. resp<<=8. If index=3, go to RX with index 0; otherwise increment index and go to TX_LOAD.
- tx_start is never asserted while tx_ready=0. Exactly 4 tx_start pulses occur per frame.
- Minimum turnaround: the first tx_start occurs 2 cycles after the rx_rcv of the 5th byte, when tx_ready is already 1.
- Asserting rstn low at any point aborts immediately: outputs return to reset values and any partial frame or response is lost.

Decomposition:
- Package serial_cmd_pkg holds:
  - the command codes 0x01-0x07;
  - response constants: RESP_CONST=0x01010101, RESP_BAD=0xFFFFFFFF, RESP_TIMEOUT=0xDEADBEEF;
  - the state enum RX, EXEC, MEM_WAIT, TX_LOAD, TX_BUSY, TX_DONE.
- One natural sub-module, serial_tx_seq: the 4-byte transmit sequencer. It takes a 32-bit word and a load pulse, returns a done pulse, and drives tx_data/tx_start from tx_ready.

Test Plan:
- Send 06 00 00 00 00 twice -> responses 00 00 00 00, then 00 00 00 01; exactly 8 tx_start pulses.
- Send 01 00 00 01 04, then 02 12 34 56 78, then 03 00 00 00 00 -> mem_addr=0x00000104, mem_wdata=0x12345678, one mem_wr_req pulse; after the mem_done model responds, bytes 00 00 00 03.
- Send 05 .. with mem_rdata=0xCAFEF00D and mem_done 10 cycles later, then 04 .. -> bytes 00 00 00 05, then CA FE F0 0D.
- Send 05 .. with mem_done never asserted -> after MEM_TIMEOUT cycles, bytes DE AD BE EF; a following 04 .. returns the previous rd_latch.
- Send 3 bytes, idle for RX_TIMEOUT+1 cycles, then send 07 00 00 00 00 -> no response to the partial frame; then 01 01 01 01.
- Send a 6th byte during transmission -> err_overrun=1, response unaffected. Also pulse rstn low mid-transmit -> tx_start=0, busy=0, count=COUNT_INIT.
